// File: rtl/tff_seq_pkg.sv
// Shared state encoding and default sizing for the T-flip-flop sequence counter.
package tff_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_COUNT = 9;

endpackage

// File: rtl/tff_bit.sv
// Single T flip-flop: synchronous active-low clear, inverts its output when t is high.
module tff_bit (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rstn)
            q <= 1'b0;
        else if (t)
            q <= ~q;
    end

endmodule

// File: rtl/tff_count_seq.sv
// Up/down modulo counter built from a bank of T flip-flops and sequenced by an IDLE/RUN FSM.
// Optional macro TFF_SEQ_AUTOSTOP_EN: a wrap step parks the FSM in HALT instead of wrapping.
module tff_count_seq
    import tff_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_COUNT = DEF_MAX_COUNT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    state_t           state;
    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] inc_t;
    logic [WIDTH-1:0] dec_t;
    logic             carry_up;
    logic             carry_dn;
    logic             step;
    logic             wrap_up;
    logic             wrap_dn;
    logic             wrap;
    logic             halt_now;

`ifdef TFF_SEQ_AUTOSTOP_EN
    logic             rearm;
`endif

    always_comb begin
        clamped = (load_val > MAX_V) ? MAX_V : load_val;
        step    = !load && (state == RUN) && !stop && tick;
        // count above MAX_V is only reachable with odd parameters; an up step treats it as a wrap
        wrap_up = dir && (count >= MAX_V);
        wrap_dn = !dir && (count == '0);
        wrap    = step && (wrap_up || wrap_dn);

`ifdef TFF_SEQ_AUTOSTOP_EN
        halt_now = wrap && !rearm;
`else
        halt_now = 1'b0;
`endif

        // ripple the increment/decrement toggle terms bit by bit
        inc_t    = '0;
        dec_t    = '0;
        inc_t[0] = 1'b1;
        dec_t[0] = 1'b1;
        carry_up = count[0];
        carry_dn = ~count[0];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            inc_t[i] = carry_up;
            dec_t[i] = carry_dn;
            carry_up = carry_up & count[i];
            carry_dn = carry_dn & ~count[i];
        end

        toggle = '0;
        if (rstn) begin
            if (load)
                toggle = count ^ clamped;
            else if (step && !halt_now) begin
                if (dir)
                    toggle = wrap_up ? count : inc_t;
                else
                    toggle = wrap_dn ? MAX_V : dec_t;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bank
        tff_bit u_bit (
            .clk  (clk),
            .rstn (rstn),
            .t    (toggle[g]),
            .q    (count[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            busy  <= 1'b0;
            tc    <= 1'b0;
`ifdef TFF_SEQ_AUTOSTOP_EN
            rearm <= 1'b0;
`endif
        end else begin
            tc <= wrap;
`ifdef TFF_SEQ_AUTOSTOP_EN
            // the first step after resuming from HALT performs the wrap instead of halting again
            rearm <= !load && !stop &&
                     (((state == HALT) && start) || ((state == RUN) && !tick && rearm));
`endif
            if (!load) begin
                case (state)
                    IDLE: begin
                        if (!stop && start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (halt_now) begin
                            state <= HALT;
                            busy  <= 1'b0;
                        end
                    end
`ifdef TFF_SEQ_AUTOSTOP_EN
                    HALT: begin
                        if (stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (start) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tff_count_seq.md
TFF_COUNT_SEQ -- requirements
Module: tff_count_seq

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..16.
REQ-002 Parameter MAX_COUNT, default 9: terminal value, legal range 1..2^WIDTH-1.
REQ-003 clk  in  1  clock; all state changes on posedge clk only.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  level; moves IDLE->RUN.
REQ-006 stop  in  1  level; moves RUN->IDLE.
REQ-007 tick  in  1  step enable; one count step per cycle with tick=1 in RUN.
REQ-008 dir  in  1  1=up, 0=down; sampled on each stepping edge.
REQ-009 load  in  1  load request; accepted in any state.
REQ-010 load_val  in  WIDTH  value for load.
REQ-011 count  out  WIDTH  current counter value, registered (T-flip-flop bank outputs).
REQ-012 toggle  out  WIDTH  combinational toggle vector applied to the T-flip-flop bank this cycle.
REQ-013 busy  out  1  registered; 1 iff state==RUN.
REQ-014 tc  out  1  registered; one-cycle pulse on the cycle after a wrap step.

Function
REQ-015 The FSM SHALL have states IDLE and RUN, plus HALT when TFF_SEQ_AUTOSTOP_EN is defined.
REQ-016 Per-edge priority SHALL be load > stop > start > tick.
REQ-017 Load: toggle = count ^ min(load_val, MAX_COUNT); count equals that value after one edge; FSM state unchanged; tick ignored that cycle.
REQ-018 IDLE with start=1 (no load or stop) SHALL go to RUN, with busy=1 after that edge; no step occurs on the transition edge.
REQ-019 RUN with stop=1 SHALL go to IDLE, with no step on that edge and count held.
REQ-020 Up step, count<MAX_COUNT: toggle[0]=1 and toggle[i]=&count[i-1:0] (binary increment).
REQ-021 Down step, count>0: toggle[0]=1 and toggle[i]=&~count[i-1:0] (binary decrement).
REQ-022 Up wrap, count==MAX_COUNT: toggle = count, giving count=0; tc=1 on the next cycle.
REQ-023 Down wrap, count==0: toggle = MAX_COUNT, giving count=MAX_COUNT; tc=1 on the next cycle.
REQ-024 Whenever no load or step occurs, toggle SHALL be all zeros and count SHALL hold.
REQ-025 Illegal count>MAX_COUNT is unreachable except via out-of-range parameters; if it occurs, an up step SHALL treat it as a wrap.
REQ-026 start in RUN and stop in IDLE SHALL be no-ops.

Reset
REQ-027 rstn=0 at an edge SHALL set count=0, state=IDLE, busy=0, tc=0, overriding all inputs including load, even mid-RUN.
REQ-028 toggle SHALL be all zeros while rstn=0.

Configuration
REQ-029 Macro TFF_SEQ_AUTOSTOP_EN.
- Defined: a wrap step SHALL be replaced by entry to HALT; count holds at MAX_COUNT (up) or 0 (down), tc pulses, and busy=0.
- HALT SHALL exit to RUN on start, or to IDLE on stop; load SHALL work in HALT.
REQ-030 Without TFF_SEQ_AUTOSTOP_EN, counting SHALL wrap continuously per REQ-022/023, and HALT SHALL not exist.

Structure
REQ-031 Package tff_seq_pkg SHALL hold the state enum (IDLE, RUN, HALT) and the default WIDTH/MAX_COUNT constants.
REQ-032 Sub-module tff_bit (single T flip-flop: synchronous active-low clear, toggle on t) SHALL be instantiated WIDTH times as the count register; the block SHALL update count only through toggle.

Verification (WIDTH=4, MAX_COUNT=9)
REQ-033 Reset, then start with tick=1 and dir=1 for 12 cycles -> count 0,1,...,9,0,1; tc=1 exactly once, the cycle after 9->0.
REQ-034 Load 3 in IDLE, start, dir=0, tick=1 -> count 3,2,1,0,9; tc pulses after 0->9.
REQ-035 load_val=14 -> count=9 (clamped); load and stop asserted together in RUN -> load taken, state still RUN.
REQ-036 tick=1 only on alternate cycles, dir=1 -> count advances once per two cycles; toggle=0 on idle cycles.
REQ-037 rstn=0 mid-RUN at count=7 -> next cycle count=0, busy=0, tc=0.
REQ-038 With TFF_SEQ_AUTOSTOP_EN, up count from 8 -> count 9, then HALT: count holds at 9, busy=0, one tc pulse; start -> RUN with next step 9->0.
